// File: rtl/gpr_ctx_xfer.sv
// Context save/restore engine on the far side of the GPR file: streams masked GPRs out
// for a save, and writes a valid/ready stream back into the register file for a restore.
module gpr_ctx_xfer #(
    parameter logic [5:0] ID_NULL = 6'h3F,
    parameter int         NREG    = 32
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            hold,
    input  logic            reqSave,
    input  logic            reqLoad,
    input  logic [NREG-1:0] regMask,
    output logic [5:0]      regIdRs,
    input  logic [63:0]     regValRs,
    output logic [5:0]      regIdRn,
    output logic [63:0]     regValRn,
    output logic            ctxOutValid,
    input  logic            ctxOutReady,
    output logic [63:0]     ctxOutData,
    output logic [4:0]      ctxOutIdx,
    input  logic            ctxInValid,
    output logic            ctxInReady,
    input  logic [63:0]     ctxInData,
    output logic            busy,
    output logic            done
);
    typedef enum logic [2:0] {IDLE, SAVE, DRAIN, LOAD, FIN} state_t;

    state_t          state, state_nx;
    logic [NREG-1:0] pending;
    logic [4:0]      idx;
    logic            pend_any, last, cap, acc;

    // Lowest set bit of the remaining mask selects the next register.
    always_comb begin
        idx = '0;
        for (int i = NREG - 1; i >= 0; i--)
            if (pending[i]) idx = i[4:0];
    end

    assign pend_any   = |pending;
    assign last       = pend_any && ((pending & (pending - NREG'(1))) == '0);
    assign regIdRs    = (state == SAVE) ? {1'b0, idx} : ID_NULL;
    assign ctxInReady = !hold && (state == LOAD) && pend_any;
    assign cap        = (state == SAVE) && pend_any && (!ctxOutValid || ctxOutReady);
    assign acc        = ctxInValid && ctxInReady;
    assign busy       = (state != IDLE);
    assign done       = (state == FIN);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset)    state <= IDLE;
        else if (!hold) state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:  if (reqSave)      state_nx = SAVE;
                   else if (reqLoad) state_nx = LOAD;
            SAVE:  if (!pend_any)        state_nx = FIN;
                   else if (cap && last) state_nx = DRAIN;
            DRAIN: if (!ctxOutValid || ctxOutReady) state_nx = FIN;
            LOAD:  if (!pend_any)        state_nx = FIN;
                   else if (acc && last) state_nx = FIN;
            FIN:   state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pending     <= '0;
            regIdRn     <= ID_NULL;
            regValRn    <= '0;
            ctxOutValid <= 1'b0;
            ctxOutData  <= '0;
            ctxOutIdx   <= '0;
        end else if (!hold) begin
            case (state)
                IDLE: if (reqSave || reqLoad) pending <= regMask;
                SAVE, DRAIN: begin
                    // Only capture into an empty or draining output slot so no beat is lost.
                    if (cap) begin
                        ctxOutData   <= regValRs;
                        ctxOutIdx    <= idx;
                        ctxOutValid  <= 1'b1;
                        pending[idx] <= 1'b0;
                    end else if (ctxOutReady) begin
                        ctxOutValid <= 1'b0;
                    end
                end
                LOAD: begin
                    if (acc) begin
                        regIdRn      <= {1'b0, idx};
                        regValRn     <= ctxInData;
                        pending[idx] <= 1'b0;
                    end else begin
                        regIdRn <= ID_NULL;
                    end
                end
                default: regIdRn <= ID_NULL;
            endcase
        end
    end
endmodule

// File: tb/tb_gpr_ctx_xfer.sv
// Directed bench for gpr_ctx_xfer: table of save scenarios plus restore, hold and reset
// sequences, with a small GPR file model on the read/write ports.
module tb_gpr_ctx_xfer;
    logic        clock = 1'b0;
    logic        reset, hold, reqSave, reqLoad;
    logic [31:0] regMask;
    logic [5:0]  regIdRs, regIdRn;
    logic [63:0] regValRs, regValRn;
    logic        ctxOutValid, ctxOutReady;
    logic [63:0] ctxOutData;
    logic [4:0]  ctxOutIdx;
    logic        ctxInValid, ctxInReady;
    logic [63:0] ctxInData;
    logic        busy, done;

    logic [63:0] gpr [32];
    int          wr_cnt;
    int          checks = 0;
    int          failures = 0;

    always #5 clock = ~clock;

    gpr_ctx_xfer dut (
        .clock(clock), .reset(reset), .hold(hold), .reqSave(reqSave), .reqLoad(reqLoad),
        .regMask(regMask), .regIdRs(regIdRs), .regValRs(regValRs), .regIdRn(regIdRn),
        .regValRn(regValRn), .ctxOutValid(ctxOutValid), .ctxOutReady(ctxOutReady),
        .ctxOutData(ctxOutData), .ctxOutIdx(ctxOutIdx), .ctxInValid(ctxInValid),
        .ctxInReady(ctxInReady), .ctxInData(ctxInData), .busy(busy), .done(done)
    );

    // GPR file model: preloaded while reset is low, ignores ID[5]=1 and writes under hold.
    assign regValRs = regIdRs[5] ? 64'd0 : gpr[regIdRs[4:0]];
    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 32; i++) gpr[i] <= 64'h1111_0000_0000_0000 + 64'(i);
            wr_cnt <= 0;
        end else if (!hold && !regIdRn[5]) begin
            gpr[regIdRn[4:0]] <= regValRn;
            wr_cnt <= wr_cnt + 1;
        end
    end

    typedef struct {
        logic [31:0] mask;
        logic [15:0] rdy;
        logic        both;
        logic        ld_busy;
        int          exp_beats;
        int          exp_done;
    } save_vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    function automatic int lowest(input logic [31:0] m);
        for (int i = 0; i < 32; i++) if (m[i]) return i;
        return 99;
    endfunction

    task automatic run_save(input save_vec_t v);
        logic [31:0] rem;
        logic        pv, pr;
        logic [63:0] pd;
        logic [4:0]  pi;
        int          nb, dc, e;
        rem = v.mask; nb = 0; dc = -1; pv = 0; pr = 0; pd = '0; pi = '0;
        regMask = v.mask; reqSave = 1; reqLoad = v.both; ctxOutReady = v.rdy[0];
        ctxInValid = 0; hold = 0;
        for (int c = 1; c < 200 && dc < 0; c++) begin
            @(posedge clock); #1;
            reqSave = 0; reqLoad = v.ld_busy; ctxOutReady = v.rdy[c % 16];
            #1;
            chk("save_rn_null", regIdRn, 6'h3F);
            chk("save_busy", busy, 1'b1);
            chk("save_in_ready", ctxInReady, 1'b0);
            if (pv && !pr) begin
                chk("save_hold_valid", ctxOutValid, 1'b1);
                chk("save_hold_data", ctxOutData, pd);
                chk("save_hold_idx", ctxOutIdx, pi);
            end
            if (ctxOutValid && ctxOutReady) begin
                e = lowest(rem);
                chk("save_idx", ctxOutIdx, 64'(e));
                chk("save_data", ctxOutData, 64'h1111_0000_0000_0000 + 64'(e));
                if (e < 32) rem[e] = 1'b0;
                nb++;
            end
            pv = ctxOutValid; pr = ctxOutReady; pd = ctxOutData; pi = ctxOutIdx;
            if (done) dc = c;
        end
        chk("save_beats", 64'(nb), 64'(v.exp_beats));
        chk("save_done_cycle", 64'(dc), 64'(v.exp_done));
        @(posedge clock); #1;
        reqLoad = 0;
        #1;
        chk("save_idle_busy", busy, 1'b0);
        chk("save_idle_done", done, 1'b0);
    endtask

    task automatic run_load(input logic [31:0] mask, input logic [63:0] base,
                            input logic [15:0] vpat, input logic [15:0] hpat,
                            input int exp_done);
        logic [31:0] rem;
        logic [5:0]  eid;
        logic [63:0] ev;
        int          k, dc, e, w0, k2;
        rem = mask; k = 0; dc = -1; eid = 6'h3F; ev = '0; w0 = wr_cnt;
        regMask = mask; reqLoad = 1; reqSave = 0; ctxOutReady = 1; hold = 0; ctxInValid = 0;
        for (int c = 1; c < 200 && dc < 0; c++) begin
            @(posedge clock); #1;
            reqLoad = 0; hold = hpat[c % 16]; ctxInValid = vpat[c % 16];
            ctxInData = base + 64'(k);
            #1;
            chk("load_out_valid", ctxOutValid, 1'b0);
            chk("load_rs_null", regIdRs, 6'h3F);
            chk("load_rn_id", regIdRn, eid);
            if (eid != 6'h3F) chk("load_rn_val", regValRn, ev);
            if (hold) begin
                chk("load_hold_ready", ctxInReady, 1'b0);
            end else begin
                chk("load_ready", ctxInReady, rem != 0);
                if (ctxInValid && rem != 0) begin
                    e = lowest(rem);
                    eid = {1'b0, 5'(e)}; ev = ctxInData; rem[e] = 1'b0; k++;
                end else begin
                    eid = 6'h3F;
                end
            end
            if (done) dc = c;
        end
        chk("load_done_cycle", 64'(dc), 64'(exp_done));
        hold = 0; ctxInValid = 0;
        @(posedge clock); #2;
        chk("load_idle_rn", regIdRn, 6'h3F);
        chk("load_writes", 64'(wr_cnt - w0), 64'($countones(mask)));
        k2 = 0;
        for (int i = 0; i < 32; i++)
            if (mask[i]) begin
                chk("load_readback", gpr[i], base + 64'(k2));
                k2++;
            end
    endtask

    save_vec_t sv[5];
    int        nb;

    initial begin
        sv[0] = '{32'hFFFF_FFFF, 16'hFFFF, 1'b0, 1'b0, 32, 34};
        sv[1] = '{32'h8000_0005, 16'h9999, 1'b0, 1'b0, 3, 8};
        sv[2] = '{32'h0000_0000, 16'hFFFF, 1'b0, 1'b0, 0, 2};
        sv[3] = '{32'h0000_0003, 16'hFFFF, 1'b1, 1'b0, 2, 4};
        sv[4] = '{32'h0000_0300, 16'hFFFF, 1'b0, 1'b1, 2, 4};

        reset = 0; hold = 0; reqSave = 0; reqLoad = 0; regMask = '0;
        ctxOutReady = 0; ctxInValid = 0; ctxInData = '0;
        #12;
        chk("rst_valid", ctxOutValid, 1'b0);
        chk("rst_rn", regIdRn, 6'h3F);
        chk("rst_rs", regIdRs, 6'h3F);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        reset = 1;
        @(posedge clock); #1;

        for (int t = 0; t < 5; t++) run_save(sv[t]);

        run_load(32'h0000_00F0, 64'hA0, 16'h005A, 16'h0000, 7);
        run_load(32'h0000_00F0, 64'hB0, 16'hFFFF, 16'h001C, 8);

        // Abort a save after five beats with an asynchronous reset between edges.
        regMask = 32'hFFFF_FFFF; reqSave = 1; ctxOutReady = 1; nb = 0;
        for (int c = 1; c < 50 && nb < 5; c++) begin
            @(posedge clock); #1;
            reqSave = 0;
            #1;
            if (ctxOutValid && ctxOutReady) nb++;
        end
        chk("abort_beats", 64'(nb), 64'd5);
        #3 reset = 0;
        #1;
        chk("abort_valid", ctxOutValid, 1'b0);
        chk("abort_data", ctxOutData, 64'd0);
        chk("abort_idx", ctxOutIdx, 5'd0);
        chk("abort_rn", regIdRn, 6'h3F);
        chk("abort_rn_val", regValRn, 64'd0);
        chk("abort_rs", regIdRs, 6'h3F);
        chk("abort_busy", busy, 1'b0);
        chk("abort_done", done, 1'b0);
        #1 reset = 1;
        run_save(sv[0]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
